// File: rtl/frame_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter.
// State encoding for the slot FSM and the parity helper used at frame accept.
package frame_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_PAR  = 2'd2,
        S_GAP  = 2'd3
    } ftx_state_t;

    // Callers zero-extend the payload; the extra zeros do not change the XOR.
    function automatic logic parity_of(input logic [63:0] v, input logic odd);
        return (^v) ^ odd;
    endfunction

endpackage

// File: rtl/frame_slot_counter.sv
// Slot position counter: loads 1 on accept, counts while busy, saturates at PERIOD.
// Decodes the payload-end, parity-slot and slot-end positions; no backpressure of its own.
module frame_slot_counter #(
    parameter int FRAME_W = 12,
    parameter int PERIOD  = 101
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic last_bit_o,
    output logic last_par_o,
    output logic slot_end_o
);
    localparam int CNT_W = $clog2(PERIOD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last_bit_o = (cnt_q == CNT_W'(FRAME_W));
    assign last_par_o = (cnt_q == CNT_W'(FRAME_W + 1));
    assign slot_end_o = (cnt_q == CNT_W'(PERIOD));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (en_i && !slot_end_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// Serialises one FRAME_W-bit frame per PERIOD-cycle slot; first bit the cycle after accept.
// frame_ready is high in IDLE or the last slot cycle (zero-gap back-to-back), low during abort.
module frame_serializer
    import frame_tx_pkg::*;
#(
    parameter int FRAME_W    = 12,
    parameter int PERIOD     = 101,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame,
    output logic               frame_ready,
    input  logic               abort,
    output logic               data_out,
    output logic               bit_active,
    output logic               busy,
    output logic               done_sending_frame
);
    ftx_state_t         state_q, state_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic               par_q, par_d;
    logic               data_q, data_d;
    logic               act_q, act_d;
    logic [FRAME_W-1:0] frame_in;
    logic               accept;
    logic               cnt_clr, cnt_load;
    logic               last_bit, last_par, slot_end;

    frame_slot_counter #(
        .FRAME_W (FRAME_W),
        .PERIOD  (PERIOD)
    ) u_slot_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .en_i       (busy),
        .last_bit_o (last_bit),
        .last_par_o (last_par),
        .slot_end_o (slot_end)
    );

    // Reversing at load lets the shifter always emit bit 0 first.
    always_comb begin
        frame_in = frame;
        if (MSB_FIRST) begin
            for (int i = 0; i < FRAME_W; i++) begin
                frame_in[i] = frame[FRAME_W-1-i];
            end
        end
    end

    assign busy               = (state_q != S_IDLE);
    assign frame_ready        = !abort && ((state_q == S_IDLE) || ((state_q == S_GAP) && slot_end));
    assign accept             = frame_valid && frame_ready;
    assign done_sending_frame = (state_q == S_GAP) && slot_end && !abort;
    assign data_out           = data_q;
    assign bit_active         = act_q;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        par_d    = par_q;
        data_d   = data_q;
        act_d    = act_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            data_d  = IDLE_LEVEL;
            act_d   = 1'b0;
            cnt_clr = 1'b1;
        end else if (accept) begin
            state_d  = S_SEND;
            sr_d     = frame_in >> 1;
            par_d    = parity_of(64'(frame_in), PARITY_ODD);
            data_d   = frame_in[0];
            act_d    = 1'b1;
            cnt_load = 1'b1;
        end else begin
            unique case (state_q)
                S_SEND: begin
                    if (!last_bit) begin
                        data_d = sr_q[0];
                        sr_d   = sr_q >> 1;
                    end else if (PARITY_EN) begin
                        state_d = S_PAR;
                        data_d  = par_q;
                    end else begin
                        state_d = S_GAP;
                        data_d  = IDLE_LEVEL;
                        act_d   = 1'b0;
                    end
                end
                S_PAR: begin
                    if (last_par) begin
                        state_d = S_GAP;
                        data_d  = IDLE_LEVEL;
                        act_d   = 1'b0;
                    end
                end
                S_GAP: begin
                    if (slot_end) begin
                        state_d = S_IDLE;
                        cnt_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            par_q   <= 1'b0;
            data_q  <= IDLE_LEVEL;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            data_q  <= data_d;
            act_q   <= act_d;
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: default config, MSB-first with odd parity,
// and a minimum-length slot, covering back-to-back, abort and mid-slot reset.
module tb_frame_serializer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        fv_a, rdy_a, ab_a, do_a, act_a, busy_a, done_a;
    logic [11:0] fr_a;
    logic        fv_b, rdy_b, ab_b, do_b, act_b, busy_b, done_b;
    logic [11:0] fr_b;
    logic        fv_c, rdy_c, ab_c, do_c, act_c, busy_c, done_c;
    logic [11:0] fr_c;

    int checks = 0;
    int errors = 0;

    // Hand-derived serial images of 12'hA5C.
    logic seq_a [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic seq_b [13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    frame_serializer u_a (
        .clk(clk), .rst_n(rst_n), .frame_valid(fv_a), .frame(fr_a), .frame_ready(rdy_a),
        .abort(ab_a), .data_out(do_a), .bit_active(act_a), .busy(busy_a),
        .done_sending_frame(done_a)
    );

    frame_serializer #(.MSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .frame_valid(fv_b), .frame(fr_b), .frame_ready(rdy_b),
        .abort(ab_b), .data_out(do_b), .bit_active(act_b), .busy(busy_b),
        .done_sending_frame(done_b)
    );

    frame_serializer #(.FRAME_W(12), .PERIOD(13)) u_c (
        .clk(clk), .rst_n(rst_n), .frame_valid(fv_c), .frame(fr_c), .frame_ready(rdy_c),
        .abort(ab_c), .data_out(do_c), .bit_active(act_c), .busy(busy_c),
        .done_sending_frame(done_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        fv_a = 1'b0; fr_a = '0; ab_a = 1'b0;
        fv_b = 1'b0; fr_b = '0; ab_b = 1'b0;
        fv_c = 1'b0; fr_c = '0; ab_c = 1'b0;
        #2;
        chk("rst_data",  do_a,   1'b0);
        chk("rst_ready", rdy_a,  1'b1);
        chk("rst_act",   act_a,  1'b0);
        chk("rst_busy",  busy_a, 1'b0);
        chk("rst_done",  done_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Single frame, LSB-first on A and MSB-first + odd parity on B.
        fv_a = 1'b1; fr_a = 12'hA5C;
        fv_b = 1'b1; fr_b = 12'hA5C;
        tick();
        fv_a = 1'b0; fr_a = 12'h3F0;
        fv_b = 1'b0; fr_b = 12'h0F3;
        for (int k = 1; k <= 101; k++) begin
            chk($sformatf("a_data_c%0d", k), do_a, (k <= 12) ? seq_a[k-1] : 1'b0);
            chk($sformatf("a_act_c%0d", k), act_a, k <= 12);
            chk($sformatf("a_done_c%0d", k), done_a, k == 101);
            chk($sformatf("a_busy_c%0d", k), busy_a, 1'b1);
            chk($sformatf("a_ready_c%0d", k), rdy_a, k == 101);
            chk($sformatf("b_data_c%0d", k), do_b, (k <= 13) ? seq_b[k-1] : 1'b0);
            chk($sformatf("b_act_c%0d", k), act_b, k <= 13);
            chk($sformatf("b_done_c%0d", k), done_b, k == 101);
            tick();
        end
        chk("a_busy_after", busy_a, 1'b0);
        chk("a_ready_after", rdy_a, 1'b1);
        chk("b_busy_after", busy_b, 1'b0);

        // Back-to-back with frame_valid held: 12'h001 then 12'h800.
        fv_a = 1'b1; fr_a = 12'h001;
        tick();
        fr_a = 12'h800;
        for (int t = 1; t <= 202; t++) begin
            if (t == 102) fv_a = 1'b0;
            chk($sformatf("b2b_data_c%0d", t), do_a, (t == 1) || (t == 113));
            chk($sformatf("b2b_done_c%0d", t), done_a, (t == 101) || (t == 202));
            chk($sformatf("b2b_busy_c%0d", t), busy_a, 1'b1);
            tick();
        end
        chk("b2b_busy_end", busy_a, 1'b0);

        // Abort blocks frame_ready even when idle.
        ab_a = 1'b1;
        #1;
        chk("abort_idle_ready", rdy_a, 1'b0);
        ab_a = 1'b0;
        #1;
        chk("idle_ready", rdy_a, 1'b1);

        // Abort in cycle 5, with a frame already offered alongside it.
        fv_a = 1'b1; fr_a = 12'hA5C;
        tick();
        fv_a = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        chk("abort_c5_data", do_a, 1'b1);
        ab_a = 1'b1; fv_a = 1'b1; fr_a = 12'h001;
        #1;
        chk("abort_c5_ready", rdy_a, 1'b0);
        chk("abort_c5_done", done_a, 1'b0);
        tick();
        ab_a = 1'b0;
        #1;
        chk("abort_c6_data", do_a, 1'b0);
        chk("abort_c6_busy", busy_a, 1'b0);
        chk("abort_c6_act", act_a, 1'b0);
        chk("abort_c6_ready", rdy_a, 1'b1);
        tick();
        fv_a = 1'b0;
        chk("restart_c1_data", do_a, 1'b1);
        chk("restart_c1_busy", busy_a, 1'b1);
        tick();
        chk("restart_c2_data", do_a, 1'b0);

        // Reset asserted in cycle 40 of the restarted slot.
        for (int k = 2; k < 40; k++) tick();
        chk("pre_rst_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", do_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_act", act_a, 1'b0);
        chk("mid_rst_ready", rdy_a, 1'b1);
        chk("mid_rst_done", done_a, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("post_rst_data_%0d", k), do_a, 1'b0);
            chk($sformatf("post_rst_busy_%0d", k), busy_a, 1'b0);
        end

        // Minimum slot on C: two back-to-back frames, abort on the second slot end.
        fv_c = 1'b1; fr_c = 12'hFFF;
        tick();
        for (int t = 1; t <= 26; t++) begin
            if (t == 14) fv_c = 1'b0;
            if (t == 26) begin
                ab_c = 1'b1;
                #1;
            end
            chk($sformatf("c_data_c%0d", t), do_c, (t % 13) != 0);
            chk($sformatf("c_done_c%0d", t), done_c, t == 13);
            chk($sformatf("c_busy_c%0d", t), busy_c, 1'b1);
            chk($sformatf("c_ready_c%0d", t), rdy_c, t == 13);
            tick();
        end
        ab_c = 1'b0;
        chk("c_end_busy", busy_c, 1'b0);
        chk("c_end_data", do_c, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
